param_fir_filter: RTL and testbench

PARAM_FIR_FILTER -- requirements
Module: param_fir_filter

---
 rtl/param_fir_filter.sv | 153 +++++++++++++++
 tb/tb_param_fir_filter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fir_filter.sv
// Time-shared FIR: one multiplier, one MAC per clock, one sample per TAPS+2 clocks.
// Optional FIR_SAT_EN: clamp the shifted result to the OUT_W range instead of wrapping.

module param_fir_filter #(
    parameter int TAPS   = 8,
    parameter int DATA_W = 16,
    parameter int COEF_W = 16,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    output logic signed [OUT_W-1:0]  data_out
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = PROD_W + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);
    localparam logic [IDX_W:0]   TAP_LIM  = (IDX_W + 1)'(TAPS);
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [ACC_W:0] RND =
        (SHIFT > 0) ? ({{ACC_W{1'b0}}, 1'b1} << RND_POS) : '0;

    typedef enum logic [1:0] {
        StIdle,
        StMac,
        StOut
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic signed [DATA_W-1:0] r_x [TAPS];
    logic signed [COEF_W-1:0] r_h [TAPS];
    logic signed [ACC_W-1:0]  r_acc;
    logic [IDX_W-1:0]         r_idx;
    logic                     r_out_valid;
    logic signed [OUT_W-1:0]  r_data_out;

    logic                     w_accept;
    logic                     w_coef_wr;
    logic                     w_last;
    logic signed [PROD_W-1:0] w_x_ext;
    logic signed [PROD_W-1:0] w_h_ext;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W:0]    w_rounded;
    logic signed [ACC_W:0]    w_shifted;
    logic signed [OUT_W-1:0]  w_result;

    assign in_ready  = (r_state == StIdle);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_idx == LAST_IDX);
    // Coefficients only change between samples, never under a running MAC.
    assign w_coef_wr = coef_we && in_ready && ({1'b0, coef_addr} < TAP_LIM);

    assign w_x_ext    = {{COEF_W{r_x[r_idx][DATA_W-1]}}, r_x[r_idx]};
    assign w_h_ext    = {{DATA_W{r_h[r_idx][COEF_W-1]}}, r_h[r_idx]};
    assign w_prod     = w_x_ext * w_h_ext;
    assign w_prod_ext = {{IDX_W{w_prod[PROD_W-1]}}, w_prod};

    // One guard bit so the rounding add cannot overflow the accumulator range.
    assign w_rounded = {r_acc[ACC_W-1], r_acc} + RND;
    assign w_shifted = w_rounded >>> SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W - OUT_W + 2){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W - OUT_W + 2){1'b1}}, {(OUT_W - 1){1'b0}}};

    always_comb begin
        w_result = w_shifted[OUT_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_result = SAT_MAX[OUT_W-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_result = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    logic w_unused_hi;

    assign w_result    = w_shifted[OUT_W-1:0];
    assign w_unused_hi = ^w_shifted[ACC_W:OUT_W];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (in_valid) w_state_next = StMac;
            StMac:   if (w_last) w_state_next = StOut;
            StOut:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < TAPS; k++) begin
                r_x[k] <= '0;
                r_h[k] <= (k == 0) ? COEF_W'(1) : '0;
            end
            r_acc       <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (w_coef_wr) begin
                r_h[coef_addr] <= coef_data;
            end
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        for (int k = TAPS - 1; k > 0; k--) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_x[0] <= data_in;
                        r_acc  <= '0;
                        r_idx  <= '0;
                    end
                end
                StMac: begin
                    r_acc <= r_acc + w_prod_ext;
                    r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
                end
                StOut: begin
                    r_data_out  <= w_result;
                    r_out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign data_out  = r_data_out;

endmodule

// File: tb/tb_param_fir_filter.sv
// Bench for param_fir_filter: table vectors, corner sequences and random samples
// checked against a direct convolution model (two instances: TAPS=4/SHIFT=0, TAPS=5/SHIFT=1).

module tb_param_fir_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               in_valid0, in_valid1, coef_we0, coef_we1;
    logic signed [15:0] data_in, coef_data;
    logic [2:0]         coef_addr;
    logic               in_ready0, in_ready1, out_valid0, out_valid1;
    logic signed [15:0] data_out0, data_out1;

    param_fir_filter #(
        .TAPS(4), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
        .data_in(data_in), .coef_we(coef_we0), .coef_addr(coef_addr[1:0]),
        .coef_data(coef_data), .out_valid(out_valid0), .data_out(data_out0)
    );

    param_fir_filter #(
        .TAPS(5), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
        .data_in(data_in), .coef_we(coef_we1), .coef_addr(coef_addr),
        .coef_data(coef_data), .out_valid(out_valid1), .data_out(data_out1)
    );

`ifdef FIR_SAT_EN
    localparam longint OVF_EXP = 32767;
`else
    localparam longint OVF_EXP = 4;
`endif

    typedef struct {
        logic signed [15:0] din;
        logic signed [15:0] dout;
    } vec_t;

    int     total = 0;
    int     bad = 0;
    int     taps_of [2] = '{4, 5};
    int     shift_of[2] = '{0, 1};
    longint hist [2][5];
    longint coef [2][5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 5; k++) begin
                hist[d][k] = 0;
                coef[d][k] = (k == 0) ? 1 : 0;
            end
        end
    endtask

    task automatic model_accept(input int d, input logic signed [15:0] s);
        for (int k = taps_of[d] - 1; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = s;
    endtask

    task automatic model_write(input int d, input int addr, input logic signed [15:0] v);
        if (addr < taps_of[d]) coef[d][addr] = v;
    endtask

    // y = round(sum x[k]*h[k] / 2^SHIFT), then clamp or keep the low 16 bits.
    function automatic logic signed [15:0] model_out(input int d);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < taps_of[d]; k++) acc += hist[d][k] * coef[d][k];
        r = acc;
        if (shift_of[d] > 0) r = (acc + (64'sd1 <<< (shift_of[d] - 1))) >>> shift_of[d];
`ifdef FIR_SAT_EN
        if (r > 32767) r = 32767;
        if (r < -32768) r = -32768;
`endif
        return r[15:0];
    endfunction

    function automatic logic rdy(input int d);
        return (d == 0) ? in_ready0 : in_ready1;
    endfunction

    function automatic logic ovalid(input int d);
        return (d == 0) ? out_valid0 : out_valid1;
    endfunction

    function automatic logic signed [15:0] dout(input int d);
        return (d == 0) ? data_out0 : data_out1;
    endfunction

    task automatic set_drive(input int d, input logic v, input logic we);
        if (d == 0) begin
            in_valid0 = v;
            coef_we0  = we;
        end else begin
            in_valid1 = v;
            coef_we1  = we;
        end
    endtask

    task automatic wait_ready(input int d, input string name);
        int n;
        n = 0;
        while (!rdy(d) && n < 20) begin
            tick();
            n++;
        end
        check(name, rdy(d), 1);
    endtask

    task automatic load_coef(input int d, input int addr, input logic signed [15:0] v);
        wait_ready(d, "ready_before_coef");
        coef_addr = 3'(addr);
        coef_data = v;
        set_drive(d, 1'b0, 1'b1);
        model_write(d, addr, v);
        tick();
        set_drive(d, 1'b0, 1'b0);
    endtask

    task automatic send(input int d, input logic signed [15:0] s, input logic we,
                        input int addr, input logic signed [15:0] cd,
                        output logic signed [15:0] got, output int lat);
        wait_ready(d, "ready_before_send");
        data_in   = s;
        coef_addr = 3'(addr);
        coef_data = cd;
        set_drive(d, 1'b1, we);
        if (we) model_write(d, addr, cd);
        model_accept(d, s);
        tick();
        set_drive(d, 1'b0, 1'b0);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!ovalid(d) && lat < 40);
        got = dout(d);
    endtask

    task automatic send_check(input int d, input logic signed [15:0] s, input logic we,
                              input int addr, input logic signed [15:0] cd, input string name);
        logic signed [15:0] got;
        int lat;
        send(d, s, we, addr, cd, got, lat);
        check({name, "_lat"}, lat, taps_of[d] + 1);
        check(name, got, model_out(d));
    endtask

    initial begin
        vec_t               t_pass[6];
        vec_t               t_imp[5];
        logic signed [15:0] got;
        int                 lat;
        int                 last_acc;
        int                 n_acc;
        int                 n_ov;
        logic               r;

        rst = 1'b0;
        in_valid0 = 1'b0; in_valid1 = 1'b0; coef_we0 = 1'b0; coef_we1 = 1'b0;
        data_in = '0; coef_data = '0; coef_addr = '0;
        model_reset();
        t_pass = '{'{16'sd1, 16'sd1}, '{16'sd2, 16'sd2}, '{16'sd0, 16'sd0},
                   '{16'sd0, 16'sd0}, '{16'sd0, 16'sd0}, '{16'sd0, 16'sd0}};
        t_imp  = '{'{16'sd1, 16'sd1}, '{16'sd0, 16'sd2}, '{16'sd0, 16'sd3},
                   '{16'sd0, 16'sd4}, '{16'sd0, 16'sd0}};

        repeat (3) tick();
        check("rst_in_ready", in_ready0, 1);
        check("rst_out_valid", out_valid0, 0);
        check("rst_data_out", data_out0, 0);
        rst = 1'b1;
        tick();

        // Identity pass-through straight out of reset.
        for (int i = 0; i < 6; i++) begin
            send(0, t_pass[i].din, 1'b0, 0, 16'sd0, got, lat);
            check("pass_lat", lat, 5);
            check("pass_data", got, t_pass[i].dout);
        end

        // Impulse response of h = {1,2,3,4}.
        for (int a = 0; a < 4; a++) load_coef(0, a, 16'(a + 1));
        for (int i = 0; i < 5; i++) begin
            send(0, t_imp[i].din, 1'b0, 0, 16'sd0, got, lat);
            check("impulse_data", got, t_imp[i].dout);
        end

        // Coefficient written in the accepting cycle applies to that sample.
        send(0, 16'sd10, 1'b1, 0, 16'sd3, got, lat);
        check("coef_same_cycle", got, 30);
        repeat (3) tick();
        check("hold_data", data_out0, 30);
        check("hold_no_strobe", out_valid0, 0);

        // A write attempted while the MAC runs is dropped.
        wait_ready(0, "ready_before_mac_write");
        data_in = 16'sd0;
        in_valid0 = 1'b1;
        model_accept(0, 16'sd0);
        tick();
        in_valid0 = 1'b0;
        coef_we0 = 1'b1; coef_addr = 3'd1; coef_data = 16'sd100;
        repeat (2) tick();
        coef_we0 = 1'b0;
        lat = 2;
        while (!out_valid0 && lat < 40) begin
            tick();
            lat++;
        end
        check("mac_write_lat", lat, 5);
        check("mac_write_data", data_out0, model_out(0));
        send_check(0, 16'sd5, 1'b0, 0, 16'sd0, "after_mac_write");

        // Full-scale overflow: clamp or wrap.
        for (int a = 0; a < 4; a++) load_coef(0, a, 16'sh7FFF);
        for (int i = 0; i < 4; i++) begin
            send(0, 16'sh7FFF, 1'b0, 0, 16'sd0, got, lat);
            check("ovf_model", got, model_out(0));
        end
        check("ovf_4th", got, OVF_EXP);

        // in_valid held high: accept every 6 clocks, strobe 5 clocks after accept.
        last_acc = -1;
        n_acc = 0;
        data_in = 16'($urandom);
        in_valid0 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            r = in_ready0;
            tick();
            if (r) begin
                if (last_acc >= 0) check("accept_gap", c - last_acc, 6);
                last_acc = c;
                n_acc++;
                model_accept(0, data_in);
                data_in = 16'($urandom);
            end
            if (out_valid0) begin
                check("stream_lat", c - last_acc, 5);
                check("stream_data", data_out0, model_out(0));
            end
        end
        in_valid0 = 1'b0;
        check("accept_count", n_acc, 7);
        repeat (8) tick();

        for (int i = 0; i < 24; i++) begin
            send_check(0, 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                       16'($urandom), "rand_dut0");
        end

        // Reset in the second MAC cycle aborts the sample and restores identity.
        load_coef(0, 0, 16'sd7);
        wait_ready(0, "ready_before_abort");
        data_in = 16'sd9;
        in_valid0 = 1'b1;
        tick();
        in_valid0 = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("abort_ready", in_ready0, 1);
        check("abort_out_valid", out_valid0, 0);
        check("abort_data_out", data_out0, 0);
        repeat (2) tick();
        rst = 1'b1;
        model_reset();
        n_ov = 0;
        repeat (10) begin
            tick();
            if (out_valid0) n_ov++;
        end
        check("abort_no_output", n_ov, 0);
        send(0, 16'sd7, 1'b0, 0, 16'sd0, got, lat);
        check("identity_restored", got, 7);

        // Out-of-range addresses are dropped; SHIFT=1 rounds half up.
        load_coef(1, 5, 16'sd50);
        load_coef(1, 7, -16'sd1);
        send(1, 16'sd3, 1'b0, 0, 16'sd0, got, lat);
        check("shift_round_lat", lat, 6);
        check("shift_round", got, 2);
        send_check(1, -16'sd3, 1'b0, 0, 16'sd0, "shift_neg");
        for (int i = 0; i < 12; i++) begin
            send_check(1, 16'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                       16'($urandom), "rand_dut1");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
